// File: rtl/ccr_unit.sv
// Condition-code register for the execute stage.
// Holds the Z/N/C flags, applies ALU flag updates and SETC/CLRC, and
// resolves JZ/JN/JC. A taken jump clears the flag it tested.
// A small shadow stack saves the flags on interrupt entry and restores
// them on RTI. stack_err is sticky until reset.
module ccr_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       alu_op,
  input  logic             op_valid,
  input  logic [2:0]       alu_flags,
  input  logic [2:0]       alu_flags_mask,
  input  logic             stall,
  input  logic             flush,
  input  logic             int_save,
  input  logic             rti_restore,
  output logic [2:0]       ccr,
  output logic             jump_taken,
  output logic [PTR_W:0]   depth,
  output logic             stack_err
);

  localparam logic [4:0]     OP_SETC   = 5'd1;
  localparam logic [4:0]     OP_CLRC   = 5'd2;
  localparam logic [4:0]     OP_JZ     = 5'd20;
  localparam logic [4:0]     OP_JN     = 5'd21;
  localparam logic [4:0]     OP_JC     = 5'd22;
  localparam logic [PTR_W:0] DEPTH_MAX = (PTR_W+1)'(DEPTH);

  logic [2:0]       ccr_r;
  logic [2:0]       ex_ccr_s;
  logic [2:0]       ccr_nxt_s;
  logic [PTR_W:0]   depth_r;
  logic [PTR_W:0]   depth_nxt_s;
  logic             err_r;
  logic             err_nxt_s;
  logic             push_s;
  logic             live_s;
  logic             jt_s;
  logic [PTR_W-1:0] push_idx_s;
  logic [PTR_W-1:0] pop_idx_s;
  logic [2:0]       stack_r [DEPTH];

  // A jump is taken when the EX op is live and the flag it tests is set.
  always_comb begin
    live_s = op_valid & ~flush & ~stall;
    jt_s   = 1'b0;
    case (alu_op)
      OP_JZ:   jt_s = live_s & ccr_r[0];
      OP_JN:   jt_s = live_s & ccr_r[1];
      OP_JC:   jt_s = live_s & ccr_r[2];
      default: jt_s = 1'b0;
    endcase
  end

  // Compute the flags that result from the EX op alone, before any stack effect.
  always_comb begin
    ex_ccr_s = ccr_r;
    if (!op_valid || flush) begin
      ex_ccr_s = ccr_r;
    end else begin
      case (alu_op)
        OP_SETC: ex_ccr_s[2] = 1'b1;
        OP_CLRC: ex_ccr_s[2] = 1'b0;
        // A taken jump clears the tested flag. A not-taken jump found the
        // flag already 0, so forcing it to 0 leaves the flags unchanged.
        OP_JZ:   ex_ccr_s[0] = 1'b0;
        OP_JN:   ex_ccr_s[1] = 1'b0;
        OP_JC:   ex_ccr_s[2] = 1'b0;
        default: ex_ccr_s = (ccr_r & ~alu_flags_mask) | (alu_flags & alu_flags_mask);
      endcase
    end
  end

  // Resolve stall, save and restore priority into the next flag and stack state.
  always_comb begin
    ccr_nxt_s   = ccr_r;
    depth_nxt_s = depth_r;
    err_nxt_s   = err_r;
    push_s      = 1'b0;
    push_idx_s  = depth_r[PTR_W-1:0];
    pop_idx_s   = depth_r[PTR_W-1:0] - PTR_W'(1);
    if (stall) begin
      ccr_nxt_s = ccr_r;
    end else if (int_save && rti_restore) begin
      err_nxt_s = 1'b1;
    end else if (rti_restore) begin
      if (depth_r != (PTR_W+1)'(0)) begin
        ccr_nxt_s   = stack_r[pop_idx_s];
        depth_nxt_s = depth_r - (PTR_W+1)'(1);
      end else begin
        err_nxt_s = 1'b1;
      end
    end else if (int_save) begin
      if (depth_r < DEPTH_MAX) begin
        push_s      = 1'b1;
        depth_nxt_s = depth_r + (PTR_W+1)'(1);
      end else begin
        err_nxt_s = 1'b1;
      end
      // The ISR always starts with clean flags, even when the push fails.
      ccr_nxt_s = 3'b000;
    end else begin
      ccr_nxt_s = ex_ccr_s;
    end
  end

  // Register the flags, the stack depth and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_r   <= 3'b000;
      depth_r <= (PTR_W+1)'(0);
      err_r   <= 1'b0;
    end else begin
      ccr_r   <= ccr_nxt_s;
      depth_r <= depth_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // On a push, write the shadow stack with the flags of the instruction completing this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_r[i] <= 3'b000;
      end
    end else if (push_s) begin
      stack_r[push_idx_s] <= ex_ccr_s;
    end
  end

  assign ccr        = ccr_r;
  assign jump_taken = jt_s;
  assign depth      = depth_r;
  assign stack_err  = err_r;

endmodule

// File: tb/tb_ccr_unit.sv
// Testbench for ccr_unit.
// A reference model built on a queue-based stack predicts every cycle.
// Each prediction goes into a scoreboard. A separate monitor compares
// jump_taken late in the cycle and the registered state just after the edge.
module tb_ccr_unit;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [4:0]     alu_op = 5'd0;
  logic           op_valid = 1'b0;
  logic [2:0]     alu_flags = 3'b000;
  logic [2:0]     alu_flags_mask = 3'b000;
  logic           stall = 1'b0;
  logic           flush = 1'b0;
  logic           int_save = 1'b0;
  logic           rti_restore = 1'b0;
  logic [2:0]     ccr;
  logic           jump_taken;
  logic [PTR_W:0] depth;
  logic           stack_err;

  ccr_unit #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .op_valid(op_valid),
    .alu_flags(alu_flags), .alu_flags_mask(alu_flags_mask), .stall(stall),
    .flush(flush), .int_save(int_save), .rti_restore(rti_restore),
    .ccr(ccr), .jump_taken(jump_taken), .depth(depth), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       jt;
    logic [2:0] ccr;
    int         depth;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;

  // Reference model state.
  logic [2:0] m_ccr = 3'b000;
  logic [2:0] m_stk[$];
  logic       m_err = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and push the model's prediction.
  task automatic step(input logic [4:0] op, input logic v, input logic [2:0] fl,
                      input logic [2:0] mk, input logic st, input logic fs,
                      input logic sv, input logic rt);
    exp_t       e;
    logic [2:0] nc;
    logic       live;
    int         b;
    @(negedge clk);
    alu_op = op; op_valid = v; alu_flags = fl; alu_flags_mask = mk;
    stall = st; flush = fs; int_save = sv; rti_restore = rt;
    live = v && !fs && !st;
    nc   = m_ccr;
    e.jt = 1'b0;
    if (op >= 5'd20 && op <= 5'd22) begin
      b = int'(op) - 20;
      e.jt = live && m_ccr[b];
      if (e.jt) nc[b] = 1'b0;
    end else if (v && !fs) begin
      if (op == 5'd1) nc[2] = 1'b1;
      else if (op == 5'd2) nc[2] = 1'b0;
      else nc = (m_ccr & ~mk) | (fl & mk);
    end
    if (st) begin
      // everything holds
    end else if (sv && rt) begin
      m_err = 1'b1;
    end else if (rt) begin
      if (m_stk.size() > 0) m_ccr = m_stk.pop_back();
      else m_err = 1'b1;
    end else if (sv) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(nc);
      else m_err = 1'b1;
      m_ccr = 3'b000;
    end else begin
      m_ccr = nc;
    end
    e.ccr = m_ccr; e.depth = m_stk.size(); e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic idle();
    step(5'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [2:0] fl, input logic sv);
    step(5'd3, 1'b1, fl, 3'b111, 1'b0, 1'b0, sv, 1'b0);
  endtask

  // Assert reset between clock edges and expect the state to clear immediately.
  task automatic reset_mid();
    @(negedge clk);
    alu_op = 5'd0; op_valid = 1'b0; alu_flags = 3'b000; alu_flags_mask = 3'b000;
    stall = 1'b0; flush = 1'b0; int_save = 1'b0; rti_restore = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ccr", int'(ccr), 0);
    check("rst_depth", int'(depth), 0);
    check("rst_err", int'(stack_err), 0);
    m_ccr = 3'b000; m_stk.delete(); m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare each scoreboard entry against the DUT.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        #3;
        check("jump_taken", int'(jump_taken), int'(sb[0].jt));
        @(posedge clk);
        #1;
        check("ccr", int'(ccr), int'(sb[0].ccr));
        check("depth", int'(depth), sb[0].depth);
        check("stack_err", int'(stack_err), int'(sb[0].err));
        void'(sb.pop_front());
      end
    end
  end

  // Watchdog that ends a stuck run.
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [4:0] op;
    int         r;
    int         waited;
    #12;
    check("por_ccr", int'(ccr), 0);
    check("por_depth", int'(depth), 0);
    check("por_err", int'(stack_err), 0);
    check("por_jt", int'(jump_taken), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU update, then repeated jump on Z
    alu(3'b101, 1'b0); idle();
    alu(3'b001, 1'b0);
    step(5'd20, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5'd20, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stall holds the flags, then CLRC
    alu(3'b110, 1'b0);
    repeat (3) step(5'd1, 1'b1, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd2, 1'b1, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5'd21, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd21, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Nested interrupts
    alu(3'b011, 1'b0);
    step(5'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    alu(3'b100, 1'b1);
    step(5'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(5'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Simultaneous save and restore at depth 1
    alu(3'b010, 1'b1);
    alu(3'b101, 1'b0);
    step(5'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    reset_mid();

    // Overflow: fifth save is dropped, then drain to expose the entries
    for (int k = 1; k <= 5; k++) alu(3'(k), 1'b1);
    repeat (5) step(5'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Depth 2, then reset between edges, then underflow
    reset_mid();
    alu(3'b110, 1'b1); alu(3'b011, 1'b1);
    reset_mid();
    step(5'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic, with an occasional reset
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) reset_mid();
      r = $urandom_range(0, 7);
      case (r)
        0: op = 5'd1;
        1: op = 5'd2;
        2: op = 5'd20;
        3: op = 5'd21;
        4: op = 5'd22;
        default: op = 5'($urandom_range(0, 31));
      endcase
      begin
        logic st;
        st = ($urandom_range(0, 9) == 0);
        step(op, ($urandom_range(0, 7) != 0), 3'($urandom), 3'($urandom), st,
             ($urandom_range(0, 9) == 0),
             (!st && $urandom_range(0, 6) == 0),
             (!st && $urandom_range(0, 6) == 0));
      end
    end

    // Drain the scoreboard within a bounded number of cycles.
    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
